// File: rtl/uart_rx.sv
// Purpose : 8N1 UART receiver (LSB first) with 2-flop rx synchroniser and centre-of-bit sampling.
// Latency : rx_valid / rx_frame_error pulse 3 + (BAUD_DIVISOR>>1) + 9*(BAUD_DIVISOR+1) clocks after rx is first captured low.
// Backpr. : none; rx_data is held only until the next good frame, so the consumer must take it before then.
//
// Ports:
//   clk100         system clock, rising edge
//   rst            synchronous reset, active high
//   rx             asynchronous serial line, idles high
//   rx_data        last correctly framed byte, held until the next good frame
//   rx_valid       one-cycle pulse when rx_data has been updated
//   rx_frame_error one-cycle pulse when the stop bit is sampled low
//   rx_busy        high whenever the receiver is not idle
module uart_rx #(
    parameter logic [9:0] BAUD_DIVISOR = 10'd868   // bit period is BAUD_DIVISOR+1 clocks
) (
    input  logic       clk100,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_error,
    output logic       rx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    // Half a bit period: moves the sampling point from the falling edge to the bit centre.
    localparam logic [9:0] HALF = BAUD_DIVISOR >> 1;

    logic       s1;
    logic       s2;
    state_t     state;
    logic [9:0] timer;
    logic [2:0] bit_idx;
    logic [7:0] shreg;

    always_ff @(posedge clk100) begin
        if (rst) begin
            s1             <= 1'b1;
            s2             <= 1'b1;
            state          <= IDLE;
            timer          <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            rx_data        <= '0;
            rx_valid       <= 1'b0;
            rx_frame_error <= 1'b0;
            rx_busy        <= 1'b0;
        end else begin
            s1             <= rx;
            s2             <= s1;
            rx_valid       <= 1'b0;
            rx_frame_error <= 1'b0;

            case (state)
                IDLE: begin
                    if (!s2) begin
                        state   <= START;
                        timer   <= HALF;
                        rx_busy <= 1'b1;
                    end
                end

                START: begin
                    if (timer != 10'd0) begin
                        timer <= timer - 10'd1;
                    end else if (s2) begin
                        // Line back high at the start-bit centre: treat as a glitch.
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end else begin
                        state   <= DATA;
                        timer   <= BAUD_DIVISOR;
                        bit_idx <= 3'd0;
                    end
                end

                DATA: begin
                    if (timer != 10'd0) begin
                        timer <= timer - 10'd1;
                    end else begin
                        // LSB arrives first, so after eight right shifts it sits in bit 0.
                        shreg <= {s2, shreg[7:1]};
                        timer <= BAUD_DIVISOR;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end

                STOP: begin
                    if (timer != 10'd0) begin
                        timer <= timer - 10'd1;
                    end else if (s2) begin
                        // Back to IDLE mid stop bit so an immediately following start edge is seen.
                        rx_data  <= shreg;
                        rx_valid <= 1'b1;
                        state    <= IDLE;
                        rx_busy  <= 1'b0;
                    end else begin
                        rx_frame_error <= 1'b1;
                        state          <= WAIT_HIGH;
                    end
                end

                WAIT_HIGH: begin
                    // Absorbs a break so a long low line produces only one error pulse.
                    if (s2) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end

                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Purpose : randomized scoreboard bench for uart_rx with BAUD_DIVISOR=15.
// Latency : expected pulse cycle computed as E0 + 3 + H + 9P from the frame start.
// Backpr. : n/a; frames are driven on a fixed P-clock bit grid like a transmitter would.
module tb_uart_rx;

    localparam int BD  = 15;
    localparam int P   = BD + 1;
    localparam int H   = BD >> 1;
    localparam int LAT = 3 + H + 9 * P;

    logic       clk100 = 1'b0;
    logic       rst    = 1'b1;
    logic       rx     = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_error;
    logic       rx_busy;

    uart_rx #(.BAUD_DIVISOR(10'd15)) dut (
        .clk100         (clk100),
        .rst            (rst),
        .rx             (rx),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_frame_error (rx_frame_error),
        .rx_busy        (rx_busy)
    );

    always #5 clk100 = ~clk100;

    int cyc = 0;
    always @(posedge clk100) cyc++;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         at;
    } exp_t;

    exp_t       sb[$];
    int         errors    = 0;
    int         checks    = 0;
    logic [7:0] last_data = 8'h00;
    bit         busy_seen = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk100);
        #1;
    endtask

    // Called at #1 after an edge; the next edge is E0 of this frame.
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit push);
        logic [9:0] bits;
        exp_t       e;
        bits = {stop, b, 1'b0};
        if (push) begin
            e.err  = !stop;
            e.data = b;
            e.at   = cyc + 1 + LAT;
            sb.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            repeat (P) step();
        end
    endtask

    // Monitor: pops expectations whenever the DUT pulses, flags overdue ones.
    always begin
        exp_t e;
        @(posedge clk100);
        #1;
        if (rx_busy) busy_seen = 1'b1;
        if (rx_valid || rx_frame_error) begin
            check("pulse_exclusive", {31'd0, rx_valid & rx_frame_error}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b err=%0b data=0x%0h at cycle %0d, expected none",
                         rx_valid, rx_frame_error, rx_data, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_kind_err", {31'd0, rx_frame_error}, {31'd0, e.err});
                check("pulse_cycle", cyc, e.at);
                if (!e.err) begin
                    check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
                    last_data = e.data;
                end else begin
                    check("rx_data_held_on_error", {24'd0, rx_data}, {24'd0, last_data});
                end
            end
        end else if (sb.size() > 0 && cyc > sb[0].at) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: no pulse by cycle %0d, expected %s at cycle %0d",
                     cyc, e.err ? "frame_error" : "valid", e.at);
        end
    end

    initial begin
        logic [7:0] vals[256];
        logic [7:0] tmp;
        int         j;
        int         w;

        // Reset state
        repeat (3) step();
        check("reset_rx_data", {24'd0, rx_data}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_frame_error", {31'd0, rx_frame_error}, 32'd0);
        check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        repeat (5) step();
        check("idle_busy", {31'd0, rx_busy}, 32'd0);

        // Single frame
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (30) step();
        check("single_drained", sb.size(), 32'd0);

        // Back-to-back frames, 160 clocks apart
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1);
        repeat (30) step();
        check("b2b_drained", sb.size(), 32'd0);

        // Glitch shorter than half a bit
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (4) step();
        rx = 1'b1;
        repeat (30) step();
        check("glitch_busy_seen", {31'd0, busy_seen}, 32'd1);
        check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
        check("glitch_data_kept", {24'd0, rx_data}, 32'h55);

        // Stop bit low followed by a break
        send_frame(8'h3C, 1'b0, 1'b1);
        repeat (500) step();
        check("break_busy_high", {31'd0, rx_busy}, 32'd1);
        check("break_data_kept", {24'd0, rx_data}, 32'h55);
        rx = 1'b1;
        repeat (5) step();
        check("break_busy_released", {31'd0, rx_busy}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b1);
        repeat (20) step();

        // Reset in the middle of data bit 3 of an abandoned frame
        rx = 1'b0;
        repeat (P) step();
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            repeat (P) step();
        end
        rx = 1'b1;
        repeat (P / 2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_data = 8'h00;
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_rx_frame_error", {31'd0, rx_frame_error}, 32'd0);
        check("midrst_rx_busy", {31'd0, rx_busy}, 32'd0);
        repeat (200) step();
        send_frame(8'h7E, 1'b1, 1'b1);
        repeat (20) step();

        // All 256 byte values in random order with random idle gaps
        for (int i = 0; i < 256; i++) vals[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j       = $urandom_range(i, 0);
            tmp     = vals[i];
            vals[i] = vals[j];
            vals[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            send_frame(vals[i], 1'b1, 1'b1);
            repeat ($urandom_range(3, 0)) step();
        end

        w = 0;
        while (sb.size() > 0 && w < 2000) begin
            step();
            w++;
        end
        check("final_drained", sb.size(), 32'd0);
        check("final_busy", {31'd0, rx_busy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
